surf_dna_reader: RTL and testbench
==================================

SURF_DNA_READER -- requirements
Module: surf_dna_reader

Interface
REQ-001 The block SHALL expose these parameters: BASE_ADR, 11'h000, Wishbone byte address of the ID/control target; DEVICE_ID, 32'h53555246 ("SURF"), expected DEVICE word; TIMEOUT, 255, maximum cycles to wait for ack per transaction.
REQ-002 The block SHALL use one clock, and its reset SHALL be synchronous and active-low.
REQ-003 The block SHALL expose these ports (name  direction  width  meaning):
- wb_clk_i  in  1  Wishbone clock
- wb_rst_n_i  in  1  synchronous active-low reset
- start_i  in  1  single-cycle request to read device DNA
- wb_cyc_o / wb_stb_o / wb_we_o  out  1  Wishbone master strobes
- wb_adr_o  out  11  byte address
- wb_dat_o  out  32  write data
- wb_sel_o  out  4  byte selects
- wb_ack_i / wb_err_i / wb_rty_i  in  1  target responses
- wb_dat_i  in  32  read data
- busy_o  out  1  sequence in progress
- done_o  out  1  one-cycle pulse when a sequence ends, whether it passes or fails
- dna_o  out  96  captured DNA, bit i = i-th bit shifted out
- dna_valid_o  out  1  dna_o holds a complete, checked read
- err_o  out  1  last sequence failed; sticky until next start
- err_code_o  out  2  01 ID mismatch, 10 timeout, 11 err/rty

Function
REQ-004 The FSM SHALL have exactly these states: IDLE, ID_RD, LOAD_WR, SHIFT_RD, GAP, FINISH.
REQ-005 In IDLE, start_i=1 SHALL move the FSM to ID_RD and clear dna_valid_o, err_o and err_code_o; start_i in any other state SHALL be ignored.
REQ-006 ID_RD SHALL issue a read at BASE_ADR+0x000; a returned word other than DEVICE_ID SHALL end the sequence with err_code 01 and no further bus cycles.
REQ-007 LOAD_WR SHALL issue a write at BASE_ADR+0x008 with wb_dat_o=32'h80000000 and wb_sel_o=4'b1000.
REQ-008 SHIFT_RD SHALL issue a read at BASE_ADR+0x008, 96 times in total, and SHALL store wb_dat_i[0] into dna_o[bitcnt], where bitcnt is a 7-bit counter counting 0..95.
REQ-009 Every read SHALL drive wb_sel_o=4'b1111 and wb_we_o=0.
REQ-010 Handshake: cyc, stb, adr, we, dat and sel SHALL be held constant until a response arrives, and cyc and stb SHALL deassert on the clock edge after the ack is sampled.
REQ-011 At least one GAP cycle with cyc=stb=0 SHALL separate consecutive transactions, so that the target's shift pulse completes before the next read.
REQ-012 Transaction order SHALL be ID_RD, GAP, LOAD_WR, GAP, then (SHIFT_RD, GAP) x96, then FINISH.
REQ-013 A per-transaction 8-bit wait counter SHALL reset at each transaction start; reaching TIMEOUT without ack, err or rty SHALL drop cyc/stb and end the sequence with err_code 10.
REQ-014 wb_err_i or wb_rty_i sampled high SHALL end the sequence with err_code 11, and SHALL take priority over wb_ack_i in the same cycle.
REQ-015 FINISH SHALL last one cycle and pulse done_o; on success it SHALL set dna_valid_o=1, and on failure it SHALL set err_o=1 and leave dna_valid_o=0. The FSM SHALL then return to IDLE.
REQ-016 busy_o SHALL be 1 in every state except IDLE.
REQ-017 dna_o SHALL hold its value between sequences and SHALL be overwritten bit by bit during a new sequence.
REQ-018 A start_i arriving in the same cycle as FINISH SHALL be ignored.

Reset
REQ-019 When wb_rst_n_i=0 is sampled, on the next edge the FSM SHALL be in IDLE with every output 0: cyc, stb, we, adr, dat, sel, busy, done, dna_o, dna_valid, err, err_code, and all counters.
REQ-020 A reset mid-transaction SHALL abort the cycle with cyc/stb low on that edge and no done_o pulse.

Verification
REQ-021 Nominal run: model target returns "SURF", then DNA pattern 96'hA5A5_0123_4567_89AB_CDEF_FEDC -> 98 transactions, done_o pulses, dna_valid_o=1, dna_o matches the pattern, err_o=0.
REQ-022 ID mismatch: target returns 32'h54555246 -> done_o pulses after 1 transaction, err_code_o=01, and no write to 0x008 is observed.
REQ-023 Timeout: target withholds ack on the 10th shift read -> cyc drops after 255 cycles, err_code_o=10, dna_valid_o=0.
REQ-024 Err/ack collision: wb_err_i and wb_ack_i both asserted on LOAD_WR -> err_code_o=11 and no shift reads are issued.
REQ-025 Reset at shift read 50 with cyc high -> next edge shows cyc=0 and dna_o=0; a subsequent start completes all 96 bits correctly.
REQ-026 Bus rule check: start_i pulsed while busy has no effect, and every transaction is followed by at least 1 cycle with stb=0.

Source files
------------

// File: rtl/surf_dna_reader.sv
// Wishbone master that reads the 96-bit device DNA from a SURF ID/control target.
// It first checks the DEVICE word. It then pulses the DNA load bit, then shifts
// the DNA out one bit per read. Every transaction is followed by an idle gap cycle.
module surf_dna_reader #(
  parameter logic [10:0] BASE_ADR  = 11'h000,
  parameter logic [31:0] DEVICE_ID = 32'h53555246,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        start_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [10:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i,
  input  logic [31:0] wb_dat_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [95:0] dna_o,
  output logic        dna_valid_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  typedef enum logic [2:0] {IDLE, ID_RD, LOAD_WR, SHIFT_RD, GAP, FINISH} state_t;
  // Records which transaction the GAP cycle just followed, so GAP knows what comes next.
  typedef enum logic [1:0] {K_ID, K_LOAD, K_SHIFT, K_LAST} kind_t;

  localparam logic [10:0] DNA_ADR  = BASE_ADR + 11'h008;
  localparam logic [7:0]  WAIT_MAX = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  kind_t      last_kind;
  logic [6:0] bitcnt;
  logic [7:0] wait_cnt;
  logic       in_bus, set_code, acked;
  logic [1:0] code_nxt;

  // Holds the state register.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) state <= IDLE;
    else             state <= state_nxt;
  end

  // Computes the next state and the bus outputs. The bus outputs are decoded from
  // state, so they stay stable for the whole transaction.
  always_comb begin
    state_nxt = state;
    in_bus    = 1'b0;
    set_code  = 1'b0;
    code_nxt  = 2'b00;
    acked     = 1'b0;
    wb_we_o   = 1'b0;
    wb_adr_o  = '0;
    wb_dat_o  = '0;
    wb_sel_o  = '0;
    case (state)
      IDLE:     if (start_i) state_nxt = ID_RD;
      ID_RD:    begin in_bus = 1'b1; wb_adr_o = BASE_ADR; wb_sel_o = 4'b1111; end
      LOAD_WR:  begin
        in_bus   = 1'b1;
        wb_adr_o = DNA_ADR;
        wb_we_o  = 1'b1;
        wb_dat_o = 32'h8000_0000;
        wb_sel_o = 4'b1000;
      end
      SHIFT_RD: begin in_bus = 1'b1; wb_adr_o = DNA_ADR; wb_sel_o = 4'b1111; end
      GAP: begin
        case (last_kind)
          K_ID:    state_nxt = LOAD_WR;
          K_LOAD:  state_nxt = SHIFT_RD;
          K_SHIFT: state_nxt = SHIFT_RD;
          default: state_nxt = FINISH;
        endcase
      end
      FINISH:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    // Response decode. err/rty beat ack. Timeout only applies when nothing answered.
    if (in_bus) begin
      if (wb_err_i || wb_rty_i) begin
        state_nxt = FINISH; set_code = 1'b1; code_nxt = 2'b11;
      end else if (wb_ack_i) begin
        if (state == ID_RD && wb_dat_i != DEVICE_ID) begin
          state_nxt = FINISH; set_code = 1'b1; code_nxt = 2'b01;
        end else begin
          state_nxt = GAP; acked = 1'b1;
        end
      end else if (wait_cnt == WAIT_MAX) begin
        state_nxt = FINISH; set_code = 1'b1; code_nxt = 2'b10;
      end
    end
    wb_cyc_o = in_bus;
    wb_stb_o = in_bus;
    busy_o   = (state != IDLE);
    done_o   = (state == FINISH);
  end

  // Handles the datapath: wait counter, DNA bit capture, sequencing and status flags.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      last_kind   <= K_ID;
      bitcnt      <= '0;
      wait_cnt    <= '0;
      dna_o       <= '0;
      dna_valid_o <= 1'b0;
      err_o       <= 1'b0;
      err_code_o  <= 2'b00;
    end else begin
      wait_cnt <= in_bus ? wait_cnt + 8'd1 : 8'd0;
      if (state == IDLE && start_i) begin
        dna_valid_o <= 1'b0;
        err_o       <= 1'b0;
        err_code_o  <= 2'b00;
        bitcnt      <= '0;
      end
      if (set_code) err_code_o <= code_nxt;
      if (acked) begin
        case (state)
          ID_RD:   last_kind <= K_ID;
          LOAD_WR: last_kind <= K_LOAD;
          default: begin
            dna_o[bitcnt] <= wb_dat_i[0];
            last_kind     <= (bitcnt == 7'd95) ? K_LAST : K_SHIFT;
            bitcnt        <= (bitcnt == 7'd95) ? 7'd0 : bitcnt + 7'd1;
          end
        endcase
      end
      if (state == FINISH) begin
        dna_valid_o <= (err_code_o == 2'b00);
        err_o       <= (err_code_o != 2'b00);
      end
    end
  end

endmodule

// File: tb/tb_surf_dna_reader.sv
// Scoreboard bench for surf_dna_reader: a Wishbone target model answers the bus,
// stimulus pushes the expected outcome per sequence, and a monitor checks it on done_o.
module tb_surf_dna_reader;
  logic        wb_clk_i = 1'b0;
  logic        wb_rst_n_i, start_i;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [10:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i, wb_err_i, wb_rty_i;
  logic [31:0] wb_dat_i;
  logic        busy_o, done_o, dna_valid_o, err_o;
  logic [95:0] dna_o;
  logic [1:0]  err_code_o;

  surf_dna_reader dut (
    .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i), .start_i(start_i),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
    .wb_dat_i(wb_dat_i), .busy_o(busy_o), .done_o(done_o), .dna_o(dna_o),
    .dna_valid_o(dna_valid_o), .err_o(err_o), .err_code_o(err_code_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic [1:0]  code;
    logic        valid;
    logic        err;
    logic [95:0] dna;
    int          ntrans;
    int          nshift;
    logic        wr8;
  } exp_t;

  exp_t sb[$];
  int checks = 0, failures = 0, mon_cnt = 0;

  // Target model controls and observations.
  logic [95:0] pat;
  logic        bad_id = 1'b0, errack = 1'b0, saw_wr8 = 1'b0;
  int          stall_at = -1, n_trans = 0, shift_idx = 0, abort_len = 0;

  localparam logic [95:0] P1 = 96'hA5A5_0123_4567_89AB_CDEF_FEDC;
  localparam logic [95:0] P2 = 96'h3C3C_F00D_1234_5678_9ABC_DEF0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Wishbone target: answers on the second cycle of each strobe, checks hold and gap rules.
  initial begin
    logic        resp;
    int          hold;
    logic [47:0] cap;
    hold = 0; cap = '0;
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_dat_i = '0;
    forever begin
      @(negedge wb_clk_i);
      resp = wb_ack_i | wb_err_i | wb_rty_i;
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_dat_i = '0;
      if (resp && wb_rst_n_i) chk("gap_after_resp", wb_stb_o, 1'b0);
      if (wb_cyc_o === 1'b1 && wb_stb_o === 1'b1) begin
        if (hold == 0) cap = {wb_adr_o, wb_we_o, wb_dat_o, wb_sel_o};
        hold++;
        if (hold >= 2 && !(wb_adr_o == 11'h008 && !wb_we_o && shift_idx == stall_at)) begin
          chk("hold_stable", {wb_adr_o, wb_we_o, wb_dat_o, wb_sel_o}, cap);
          n_trans++;
          wb_ack_i = 1'b1;
          if (wb_adr_o == 11'h000 && !wb_we_o) begin
            wb_dat_i = bad_id ? 32'h54555246 : 32'h53555246;
          end else if (wb_adr_o == 11'h008 && wb_we_o) begin
            saw_wr8 = 1'b1;
            chk("load_wr_fields", {wb_dat_o, wb_sel_o}, {32'h8000_0000, 4'b1000});
            if (errack) wb_err_i = 1'b1;
          end else if (wb_adr_o == 11'h008) begin
            chk("shift_rd_sel", wb_sel_o, 4'b1111);
            wb_dat_i = {31'b0, pat[shift_idx]};
            shift_idx++;
          end
        end
      end else begin
        if (hold > 0 && !resp) abort_len = hold;
        hold = 0;
      end
    end
  end

  // Monitor: on each done_o pulse, pop the expected outcome and compare final status.
  initial begin
    exp_t e;
    forever begin
      @(negedge wb_clk_i);
      if (done_o === 1'b1) begin
        @(posedge wb_clk_i); #1;
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done act=done exp=none");
        end else begin
          e = sb.pop_front();
          chk("err_code",  err_code_o,  e.code);
          chk("dna_valid", dna_valid_o, e.valid);
          chk("err",       err_o,       e.err);
          chk("dna",       dna_o,       e.dna);
          chk("ntrans",    n_trans,     e.ntrans);
          chk("nshift",    shift_idx,   e.nshift);
          chk("wr8_seen",  saw_wr8,     e.wr8);
        end
        mon_cnt++;
      end
    end
  end

  task automatic run(input exp_t e, input bit poke_busy, input bit poke_fin);
    int m0;
    bit ok;
    m0 = mon_cnt; ok = 0;
    sb.push_back(e);
    n_trans = 0; shift_idx = 0; saw_wr8 = 1'b0;
    @(negedge wb_clk_i); start_i = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge wb_clk_i);
      start_i = (poke_busy && c == 20);
      if (c == 0) chk("clear_on_start", {busy_o, dna_valid_o, err_o, err_code_o}, 5'b10000);
      if (poke_fin && done_o === 1'b1) begin
        start_i = 1'b1;
        @(posedge wb_clk_i); #1;
        chk("start_in_finish_ignored", busy_o, 1'b0);
        start_i = 1'b0;
      end
      if (mon_cnt != m0) begin ok = 1; break; end
    end
    start_i = 1'b0;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL done_timeout act=no_done exp=done");
    end
  endtask

  initial begin
    exp_t e;
    logic [95:0] mix;
    bit found;
    wb_rst_n_i = 1'b0; start_i = 1'b0; pat = P1;
    repeat (3) @(negedge wb_clk_i);
    chk("reset_outputs", {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
                          busy_o, done_o, dna_valid_o, err_o, err_code_o}, '0);
    chk("reset_dna", dna_o, '0);
    wb_rst_n_i = 1'b1;
    repeat (2) @(negedge wb_clk_i);

    // Nominal read with a start poked while busy and again in the FINISH cycle.
    e = '{2'b00, 1'b1, 1'b0, P1, 98, 96, 1'b1};
    run(e, 1'b1, 1'b1);

    // ID mismatch: one transaction, no load write, DNA retained.
    bad_id = 1'b1;
    e = '{2'b01, 1'b0, 1'b1, P1, 1, 0, 1'b0};
    run(e, 1'b0, 1'b0);
    bad_id = 1'b0;

    // Timeout on the 10th shift read: bits 0..8 come from the new pattern.
    pat = P2; stall_at = 9; abort_len = 0;
    mix = P1; mix[8:0] = P2[8:0];
    e = '{2'b10, 1'b0, 1'b1, mix, 11, 9, 1'b1};
    run(e, 1'b0, 1'b0);
    chk("timeout_len", abort_len, 255);
    stall_at = -1;

    // err and ack together on the load write.
    errack = 1'b1;
    e = '{2'b11, 1'b0, 1'b1, mix, 2, 0, 1'b1};
    run(e, 1'b0, 1'b0);
    errack = 1'b0;

    // Reset during shift read 50, then a full read must rebuild every bit.
    n_trans = 0; shift_idx = 0; saw_wr8 = 1'b0; found = 0;
    @(negedge wb_clk_i); start_i = 1'b1;
    @(negedge wb_clk_i); start_i = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (shift_idx == 50 && wb_cyc_o === 1'b1) begin found = 1; break; end
      @(negedge wb_clk_i);
    end
    if (!found) begin
      checks++; failures++;
      $display("FAIL reach_shift50 act=not_reached exp=reached");
    end
    wb_rst_n_i = 1'b0;
    @(posedge wb_clk_i); #1;
    chk("midreset_cyc", {wb_cyc_o, wb_stb_o, busy_o}, 3'b000);
    chk("midreset_dna", dna_o, '0);
    @(negedge wb_clk_i); wb_rst_n_i = 1'b1;
    repeat (4) @(negedge wb_clk_i);

    e = '{2'b00, 1'b1, 1'b0, P2, 98, 96, 1'b1};
    run(e, 1'b0, 1'b0);
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
